// File: rtl/tile_sched_ctrl_nn.sv
// Tile/layer sequencer for the systolic NN datapath: per layer, one load phase per
// row tile followed by one layering phase, with handshake timeout and abort.
module tile_sched_ctrl_nn #(
  parameter int N          = 8,
  parameter int TILE       = 4,
  parameter int NUM_LAYERS = 2,
  parameter int TIMEOUT    = 16,
  parameter int TW         = 3,
  parameter int LW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          load_busy,
  input  logic          layer_busy,
  output logic [2:0]    mode,
  output logic          start_load,
  output logic          start_layer,
  output logic          next_tile,
  output logic [TW-1:0] tile_idx,
  output logic [LW-1:0] layer_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int NUM_TILES = N / TILE;
  localparam int CW        = $clog2(TIMEOUT);

  localparam logic [TW-1:0] LAST_TILE  = TW'(NUM_TILES - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [CW-1:0] LAST_WAIT  = CW'(TIMEOUT - 1);

  localparam logic [2:0] MODE_IDLE  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_LAYER = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE_LOAD,
    S_WAIT_LOAD_ON,
    S_WAIT_LOAD_OFF,
    S_NEXT_TILE,
    S_ISSUE_LAYER,
    S_WAIT_LAY_ON,
    S_WAIT_LAY_OFF,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [TW-1:0]   tile_n;
  logic [LW-1:0]   layer_n;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   wait_cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tile_idx  <= '0;
      layer_idx <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      tile_idx  <= tile_n;
      layer_idx <= layer_n;
      wait_cnt  <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    tile_n     = tile_idx;
    layer_n    = layer_idx;
    wait_cnt_n = wait_cnt;

    case (state)
      S_IDLE: begin
        tile_n  = '0;
        layer_n = '0;
        if (start && !load_busy && !layer_busy) begin
          state_n = S_ISSUE_LOAD;
        end
      end

      S_ISSUE_LOAD: begin
        wait_cnt_n = '0;
        state_n    = S_WAIT_LOAD_ON;
      end

      S_WAIT_LOAD_ON: begin
        if (load_busy) begin
          state_n = S_WAIT_LOAD_OFF;
        end else if (wait_cnt == LAST_WAIT) begin
          state_n = S_ERR;
        end else begin
          wait_cnt_n = wait_cnt + CW'(1);
        end
      end

      // The busy-off wait is unbounded: a sub-controller that started is trusted to finish.
      S_WAIT_LOAD_OFF: begin
        if (!load_busy) begin
          if (tile_idx < LAST_TILE) begin
            state_n = S_NEXT_TILE;
          end else begin
            tile_n  = '0;
            state_n = S_ISSUE_LAYER;
          end
        end
      end

      S_NEXT_TILE: begin
        tile_n  = tile_idx + TW'(1);
        state_n = S_ISSUE_LOAD;
      end

      S_ISSUE_LAYER: begin
        wait_cnt_n = '0;
        state_n    = S_WAIT_LAY_ON;
      end

      S_WAIT_LAY_ON: begin
        if (layer_busy) begin
          state_n = S_WAIT_LAY_OFF;
        end else if (wait_cnt == LAST_WAIT) begin
          state_n = S_ERR;
        end else begin
          wait_cnt_n = wait_cnt + CW'(1);
        end
      end

      S_WAIT_LAY_OFF: begin
        if (!layer_busy) begin
          if (layer_idx < LAST_LAYER) begin
            layer_n = layer_idx + LW'(1);
            state_n = S_ISSUE_LOAD;
          end else begin
            state_n = S_DONE;
          end
        end
      end

      S_DONE: begin
        tile_n  = '0;
        layer_n = '0;
        state_n = S_IDLE;
      end

      // Indices stay frozen here so the failing tile/layer remains visible.
      S_ERR: begin
        if (start || abort) begin
          tile_n  = '0;
          layer_n = '0;
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (abort && state != S_IDLE && state != S_DONE) begin
      state_n = S_IDLE;
      tile_n  = '0;
      layer_n = '0;
    end
  end

  always_comb begin
    mode        = MODE_IDLE;
    start_load  = 1'b0;
    start_layer = 1'b0;
    next_tile   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    busy        = (state != S_IDLE);

    case (state)
      S_ISSUE_LOAD: begin
        mode       = MODE_LOAD;
        start_load = 1'b1;
      end
      S_WAIT_LOAD_ON, S_WAIT_LOAD_OFF: begin
        mode = MODE_LOAD;
      end
      S_NEXT_TILE: begin
        mode      = MODE_LOAD;
        next_tile = 1'b1;
      end
      S_ISSUE_LAYER: begin
        mode        = MODE_LAYER;
        start_layer = 1'b1;
      end
      S_WAIT_LAY_ON, S_WAIT_LAY_OFF: begin
        mode = MODE_LAYER;
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        mode = MODE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tile_sched_ctrl_nn.sv
// Scoreboard bench for tile_sched_ctrl_nn: a nominal 2x2 instance and a 1-tile/1-layer
// instance driven by randomized busy responders, with expected pulse events queued per run.
module tb_tile_sched_ctrl_nn;

  localparam int TIMEOUT = 16;
  localparam int K_LOAD  = 0;
  localparam int K_NEXT  = 1;
  localparam int K_LAYER = 2;
  localparam int K_DONE  = 3;
  localparam int K_ERR   = 4;

  typedef struct {
    int kind;
    int tile;
    int layer;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, abort0, start1, abort1;
  logic       load_resp0, layer_busy0, load_busy1, layer_busy1;
  logic       load_force0;
  logic       load_busy0;
  logic       load_en0  = 1'b1;
  logic       layer_en0 = 1'b1;
  logic [2:0] mode0, mode1;
  logic       start_load0, start_layer0, next_tile0, busy0, done0, err0;
  logic       start_load1, start_layer1, next_tile1, busy1, done1, err1;
  logic [2:0] tile_idx0, tile_idx1;
  logic [3:0] layer_idx0, layer_idx1;

  ev_t exp_q0[$];
  ev_t exp_q1[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  assign load_busy0 = load_resp0 | load_force0;

  tile_sched_ctrl_nn #(.N(8), .TILE(4), .NUM_LAYERS(2), .TIMEOUT(TIMEOUT), .TW(3), .LW(4)) dut (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .load_busy(load_busy0), .layer_busy(layer_busy0),
    .mode(mode0), .start_load(start_load0), .start_layer(start_layer0), .next_tile(next_tile0),
    .tile_idx(tile_idx0), .layer_idx(layer_idx0), .busy(busy0), .done(done0), .err(err0)
  );

  tile_sched_ctrl_nn #(.N(4), .TILE(4), .NUM_LAYERS(1), .TIMEOUT(TIMEOUT), .TW(3), .LW(4)) dut_small (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .load_busy(load_busy1), .layer_busy(layer_busy1),
    .mode(mode1), .start_load(start_load1), .start_layer(start_layer1), .next_tile(next_tile1),
    .tile_idx(tile_idx1), .layer_idx(layer_idx1), .busy(busy1), .done(done1), .err(err1)
  );

  // Responders: raise busy 1..3 cycles after a start pulse and hold it 1..4 cycles.
  initial begin
    load_resp0 = 1'b0;
    forever begin
      @(negedge clk);
      if (start_load0 && load_en0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        load_resp0 = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        load_resp0 = 1'b0;
      end
    end
  end

  initial begin
    layer_busy0 = 1'b0;
    forever begin
      @(negedge clk);
      if (start_layer0 && layer_en0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        layer_busy0 = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        layer_busy0 = 1'b0;
      end
    end
  end

  initial begin
    load_busy1 = 1'b0;
    forever begin
      @(negedge clk);
      if (start_load1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        load_busy1 = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        load_busy1 = 1'b0;
      end
    end
  end

  initial begin
    layer_busy1 = 1'b0;
    forever begin
      @(negedge clk);
      if (start_layer1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        layer_busy1 = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        layer_busy1 = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input int d, input int kind, input int tile, input int layer);
    ev_t e;
    e.kind  = kind;
    e.tile  = tile;
    e.layer = layer;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Reference: every layer loads each tile in order, then runs one layering phase.
  task automatic push_run(input int d, input int num_tiles, input int num_layers);
    for (int l = 0; l < num_layers; l++) begin
      for (int t = 0; t < num_tiles; t++) begin
        push(d, K_LOAD, t, l);
        if (t < num_tiles - 1) push(d, K_NEXT, t, l);
      end
      push(d, K_LAYER, 0, l);
    end
    push(d, K_DONE, 0, num_layers - 1);
  endtask

  task automatic observe(input int d, input logic sl, input logic nt, input logic ly,
                         input logic dn, input logic er_rise, input int tile, input int layer,
                         input int md);
    int  kind;
    int  exp_mode;
    ev_t e;
    kind = -1;
    if (sl)           kind = K_LOAD;
    else if (nt)      kind = K_NEXT;
    else if (ly)      kind = K_LAYER;
    else if (dn)      kind = K_DONE;
    else if (er_rise) kind = K_ERR;
    if (kind < 0) return;
    check($sformatf("dut%0d_pulse_onehot", d), int'(sl) + int'(nt) + int'(ly) + int'(dn),
          (kind == K_ERR) ? 0 : 1);
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d_unexpected_event: actual kind %0d required none", d, kind);
      return;
    end
    if (d == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    exp_mode = (e.kind == K_LOAD || e.kind == K_NEXT) ? 1 : ((e.kind == K_LAYER) ? 2 : 0);
    check($sformatf("dut%0d_ev_kind", d), kind, e.kind);
    check($sformatf("dut%0d_ev_tile", d), tile, e.tile);
    check($sformatf("dut%0d_ev_layer", d), layer, e.layer);
    check($sformatf("dut%0d_ev_mode", d), md, exp_mode);
  endtask

  task automatic run_monitor();
    logic err0_d;
    logic err1_d;
    err0_d = 1'b0;
    err1_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        observe(0, start_load0, next_tile0, start_layer0, done0, err0 && !err0_d,
                int'(tile_idx0), int'(layer_idx0), int'(mode0));
        observe(1, start_load1, next_tile1, start_layer1, done1, err1 && !err1_d,
                int'(tile_idx1), int'(layer_idx1), int'(mode1));
      end
      err0_d = err0;
      err1_d = err1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    if (d == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_ready(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = (d == 0) ? (!busy0 && !load_busy0 && !layer_busy0)
                    : (!busy1 && !load_busy1 && !layer_busy1);
    end
    check($sformatf("dut%0d_ready", d), ok, 1);
  endtask

  // Random start noise while the run is active must be ignored.
  task automatic run_to_done(input int d);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (d == 0) start0 = ($urandom_range(0, 3) == 0);
      else        start1 = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      seen = (d == 0) ? done0 : done1;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    check($sformatf("dut%0d_done_seen", d), seen, 1);
    @(negedge clk);
    check($sformatf("dut%0d_busy_after_done", d), (d == 0) ? busy0 : busy1, 0);
    check($sformatf("dut%0d_tile_after_done", d), (d == 0) ? tile_idx0 : tile_idx1, 0);
    check($sformatf("dut%0d_layer_after_done", d), (d == 0) ? layer_idx0 : layer_idx1, 0);
    check($sformatf("dut%0d_queue_drained", d),
          (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  task automatic full_run(input int d);
    wait_ready(d);
    repeat ($urandom_range(0, 3)) tick();
    if (d == 0) push_run(0, 2, 2);
    else        push_run(1, 1, 1);
    pulse_start(d);
    @(negedge clk);
    check($sformatf("dut%0d_start_latency", d), (d == 0) ? start_load0 : start_load1, 1);
    run_to_done(d);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;
    int loads;
    rst         = 1'b1;
    start0      = 1'b0;
    abort0      = 1'b0;
    start1      = 1'b0;
    abort1      = 1'b0;
    load_force0 = 1'b0;
    fork
      run_monitor();
    join_none

    // Reset state
    @(negedge clk);
    check("rst_mode", mode0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_start_load", start_load0, 0);
    check("rst_tile", tile_idx0, 0);
    check("rst_layer", layer_idx0, 0);
    check("rst_small_busy", busy1, 0);
    rst = 1'b0;

    // Nominal and degenerate runs
    for (int r = 0; r < 3; r++) full_run(0);
    for (int r = 0; r < 2; r++) full_run(1);

    // Start gating on busy sub-controllers
    wait_ready(0);
    load_force0 = 1'b1;
    start0 = 1'b1;
    tick();
    tick();
    start0 = 1'b0;
    @(negedge clk);
    check("gated_busy", busy0, 0);
    check("gated_start_load", start_load0, 0);
    tick();
    load_force0 = 1'b0;
    push_run(0, 2, 2);
    pulse_start(0);
    @(negedge clk);
    check("ungated_start_load", start_load0, 1);
    run_to_done(0);

    // Load handshake timeout, cleared by start
    wait_ready(0);
    load_en0 = 1'b0;
    push(0, K_LOAD, 0, 0);
    push(0, K_ERR, 0, 0);
    pulse_start(0);
    @(negedge clk);
    check("to_start_load", start_load0, 1);
    repeat (TIMEOUT) @(negedge clk);
    check("to_err_early", err0, 0);
    check("to_mode_waiting", mode0, 1);
    @(negedge clk);
    check("to_err", err0, 1);
    check("to_mode", mode0, 0);
    check("to_tile", tile_idx0, 0);
    check("to_busy", busy0, 1);
    repeat (2) @(negedge clk);
    check("to_err_held", err0, 1);
    pulse_start(0);
    @(negedge clk);
    check("to_err_cleared", err0, 0);
    check("to_idle", busy0, 0);
    repeat (3) tick();
    check("to_no_restart", busy0, 0);
    load_en0 = 1'b1;

    // Layer handshake timeout, cleared by abort
    wait_ready(0);
    layer_en0 = 1'b0;
    push(0, K_LOAD, 0, 0);
    push(0, K_NEXT, 0, 0);
    push(0, K_LOAD, 1, 0);
    push(0, K_LAYER, 0, 0);
    push(0, K_ERR, 0, 0);
    pulse_start(0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = err0;
    end
    check("lto_err_seen", seen, 1);
    check("lto_layer", layer_idx0, 0);
    check("lto_mode", mode0, 0);
    tick();
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    @(negedge clk);
    check("lto_err_cleared", err0, 0);
    check("lto_idle", busy0, 0);
    layer_en0 = 1'b1;

    // Abort during ISSUE_LOAD: the pulse still appears, then IDLE
    wait_ready(0);
    push(0, K_LOAD, 0, 0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    @(negedge clk);
    check("abort_issue_idle", busy0, 0);
    check("abort_issue_no_pulse", start_load0, 0);

    // Abort in WAIT_LAY_OFF of layer 0
    wait_ready(0);
    push(0, K_LOAD, 0, 0);
    push(0, K_NEXT, 0, 0);
    push(0, K_LOAD, 1, 0);
    push(0, K_LAYER, 0, 0);
    pulse_start(0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = layer_busy0;
    end
    check("abort_layer_busy_seen", seen, 1);
    tick();
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    @(negedge clk);
    check("abort_busy", busy0, 0);
    check("abort_tile", tile_idx0, 0);
    check("abort_layer", layer_idx0, 0);
    check("abort_mode", mode0, 0);
    check("abort_no_done", done0, 0);
    repeat (5) @(negedge clk);
    check("abort_queue_drained", exp_q0.size(), 0);
    full_run(0);

    // Asynchronous reset while waiting for the second tile's load busy
    wait_ready(0);
    push_run(0, 2, 2);
    pulse_start(0);
    loads = 0;
    for (int i = 0; i < 200 && loads < 2; i++) begin
      @(negedge clk);
      if (start_load0) loads++;
    end
    check("ar_second_load_seen", loads, 2);
    @(posedge clk);
    #2;
    check("ar_pre_tile", tile_idx0, 1);
    check("ar_pre_mode", mode0, 1);
    rst = 1'b1;
    #1;
    check("ar_busy", busy0, 0);
    check("ar_mode", mode0, 0);
    check("ar_tile", tile_idx0, 0);
    check("ar_layer", layer_idx0, 0);
    check("ar_start_load", start_load0, 0);
    exp_q0.delete();
    start0 = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("ar_start_ignored", busy0, 0);
    start0 = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    check("ar_idle_after", busy0, 0);

    // Closing randomized runs on both instances
    full_run(0);
    full_run(1);
    repeat (4) tick();
    check("final_queue0", exp_q0.size(), 0);
    check("final_queue1", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_sched_ctrl_nn.md
Name: tile_sched_ctrl_nn

Overview:
Parametrised top-level sequencer for the systolic NN datapath. It generalises the single-pass load/layer controller to NUM_TILES row tiles and NUM_LAYERS layers. For each layer it issues one load phase per tile, then one layering phase. It tracks tile and layer indices, times out on handshakes that never start, and supports abort.
It drives the valid/weight/layering sub-controllers and the accumulator tile select.

Parameters:
N, 8, matrix dimension; must be a multiple of TILE and at least TILE.
TILE, 4, systolic tile edge; NUM_TILES = N/TILE (localparam).
NUM_LAYERS, 2, layers per run; at least 1.
TIMEOUT, 16, max cycles spent in a WAIT_*_ON state before error; at least 2.
TW, 3, width of tile_idx; must satisfy 2^TW >= NUM_TILES.
LW, 4, width of layer_idx; must satisfy 2^LW >= NUM_LAYERS.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  run request; sampled only in IDLE and ERR
abort  in  1  cancel the current run; highest priority
load_busy  in  1  busy from the load-path sub-controllers (valid/weight pipelines)
layer_busy  in  1  busy from the layering sub-controller
mode  out  3  0 idle, 1 load, 2 layer; feeds the weight pipeline controller
start_load  out  1  1-cycle pulse; starts weights, input and valid pipelines
start_layer  out  1  1-cycle pulse; starts the layering pipeline
next_tile  out  1  1-cycle pulse between consecutive load tiles
tile_idx  out  TW  current row tile; also the accumulator select
layer_idx  out  LW  current layer
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  1-cycle pulse when a run completes
err  out  1  handshake timeout flag; held high while in ERR

Behaviour:
- Single state register; reset is asynchronous and active-high.
- All outputs are decoded from registered state and registered counters only, so they are glitch-free and have no combinational path from inputs.
- Reset: state=IDLE, tile_idx=0, layer_idx=0, timeout counter=0; all outputs 0.
- States: IDLE, ISSUE_LOAD, WAIT_LOAD_ON, WAIT_LOAD_OFF, NEXT_TILE, ISSUE_LAYER, WAIT_LAY_ON, WAIT_LAY_OFF, DONE, ERR.
- IDLE: if start && !load_busy && !layer_busy, go to ISSUE_LOAD; otherwise stay. tile_idx and layer_idx are held at 0.
- ISSUE_LOAD: start_load=1, mode=1. Go to WAIT_LOAD_ON unconditionally.
- WAIT_LOAD_ON: mode=1.
  - load_busy=1: go to WAIT_LOAD_OFF.
  - Else if the counter equals TIMEOUT-1: go to ERR.
  - Else increment the counter.
  - The counter clears on every entry to a WAIT_*_ON state.
- WAIT_LOAD_OFF: mode=1. When load_busy=0:
  - tile_idx < NUM_TILES-1: go to NEXT_TILE.
  - Else: go to ISSUE_LAYER and set tile_idx=0.
  - No timeout applies in this state.
- NEXT_TILE: next_tile=1, mode=1, tile_idx increments. Go to ISSUE_LOAD.
- ISSUE_LAYER: start_layer=1, mode=2. Go to WAIT_LAY_ON.
- WAIT_LAY_ON: mode=2. Same rules as WAIT_LOAD_ON, using layer_busy.
- WAIT_LAY_OFF: mode=2. When layer_busy=0:
  - layer_idx < NUM_LAYERS-1: layer_idx increments; go to ISSUE_LOAD.
  - Else: go to DONE.
- DONE: done=1, mode=0. Clear both indices; go to IDLE.
- ERR: err=1, mode=0. Indices are frozen, showing the failing tile/layer.
  - start=1: clear err and both indices; go to IDLE. A new run then needs a further start in IDLE.
  - abort=1: same as start.
- abort:
  - In any state other than IDLE and DONE, abort forces IDLE on the next edge.
  - Both indices clear, no pulse is emitted that cycle, and done is not asserted.
  - If abort is sampled in ISSUE_LOAD or ISSUE_LAYER, the pulse for that cycle is still emitted (it is state-decoded); the next state is IDLE.
  - In DONE, abort is ignored.
- start while busy=1 (except in ERR) is ignored and not queued.
- Wrap: tile_idx never exceeds NUM_TILES-1; layer_idx never exceeds NUM_LAYERS-1.
- NUM_TILES=1: NEXT_TILE is never entered.
- Latency: start sampled at edge k gives start_load high during cycle k+1.
- Per layer: NUM_TILES start_load pulses, NUM_TILES-1 next_tile pulses, 1 start_layer pulse.

Test Plan:
- Nominal run (N=8, TILE=4, NUM_LAYERS=2; responders raise busy 1 cycle after each pulse and hold it 3 cycles); start 1 cycle:
  - 4 start_load pulses with tile_idx 0,1,0,1.
  - 2 next_tile pulses.
  - 2 start_layer pulses with layer_idx 0,1.
  - Exactly 1 done pulse; busy falls in the cycle after done.
- Start gating: start with load_busy=1 held -> stays IDLE, busy=0. Release load_busy, pulse start -> start_load on the next cycle.
- Timeout: load responder never asserts busy -> err=1 exactly TIMEOUT cycles after entering WAIT_LOAD_ON, tile_idx=0, mode=0. Pulse start -> err=0, IDLE.
- Abort mid-run: abort asserted in WAIT_LAY_OFF of layer 0 -> next cycle IDLE, tile_idx=0, layer_idx=0, no done. A fresh start then runs to completion.
- Degenerate sizes: N=4, TILE=4, NUM_LAYERS=1 -> 1 start_load, 0 next_tile, 1 start_layer, 1 done.
- Asynchronous reset asserted mid-WAIT_LOAD_ON -> all outputs 0 immediately without a clock edge; start ignored while rst=1.
